// File: rtl/add8_rr_arb.sv
// Four requesters share one exact 8-bit adder under a round-robin arbiter.
// A single result register holds the sum until the consumer accepts it.
module add8_rr_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [3:0]       req_ready,
  output logic             rsp_valid,
  output logic [8:0]       rsp_sum,
  output logic [1:0]       rsp_id,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0]       r_ptr;
  logic             r_rsp_valid;
  logic [8:0]       r_rsp_sum;
  logic [1:0]       r_rsp_id;
  logic [CNT_W-1:0] r_op_count;

  logic       w_stall;
  logic       w_consume;
  logic       w_xfer;
  logic       w_grant_any;
  logic [1:0] w_grant_idx;
  logic [3:0] w_grant;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [8:0] w_sum;

  assign w_stall   = r_rsp_valid & ~rsp_ready;
  assign w_consume = r_rsp_valid & rsp_ready;

  // Walk from the highest rotation down so the nearest requester at or after
  // r_ptr is the last one written and therefore wins.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_grant_idx = r_ptr;
    w_grant_any = 1'b0;
    idx         = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = r_ptr + 2'(k);
      if (req_valid[idx]) begin
        w_grant_idx = idx;
        w_grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant = 4'b0000;
    if (w_grant_any && !w_stall && !rst) begin
      w_grant = 4'b0001 << w_grant_idx;
    end
  end

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  // AND-OR operand mux: only the granted lane can reach the adder.
  always_comb begin
    w_a = 8'h00;
    w_b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      w_a = w_a | (req_a[8*i +: 8] & {8{w_grant[i]}});
      w_b = w_b | (req_b[8*i +: 8] & {8{w_grant[i]}});
    end
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= 9'h000;
      r_rsp_id    <= 2'd0;
      r_op_count  <= '0;
    end else begin
      if (w_xfer) begin
        r_rsp_valid <= 1'b1;
        r_rsp_sum   <= w_sum;
        r_rsp_id    <= w_grant_idx;
        r_ptr       <= w_grant_idx + 2'd1;
      end else if (w_consume) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_consume && (r_op_count != {CNT_W{1'b1}})) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;
  assign op_count  = r_op_count;

endmodule
